// File: rtl/axi_regfile_v2.sv
// axi_regfile_v2: parametrised AXI4-Lite slave register file.
// Independent AW/W holders feed a single commit point. Registers can be
// read-only or self-clearing. Per-register write/read strobes let user
// logic attach side effects such as FIFO pops or command triggers.
module axi_regfile_v2 #(
    parameter int                C_S_AXI_DATA_WIDTH = 32,
    parameter int                C_S_AXI_ADDR_WIDTH = 8,
    parameter int                NREGS              = 32,
    parameter logic [NREGS-1:0]  RO_MASK            = '0,
    parameter logic [NREGS-1:0]  PULSE_MASK         = '0
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic [2:0]                                 S_AXI_AWPROT,
    input  logic                                       S_AXI_AWVALID,
    output logic                                       S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                       S_AXI_WVALID,
    output logic                                       S_AXI_WREADY,
    output logic [1:0]                                 S_AXI_BRESP,
    output logic                                       S_AXI_BVALID,
    input  logic                                       S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic [2:0]                                 S_AXI_ARPROT,
    input  logic                                       S_AXI_ARVALID,
    output logic                                       S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                                 S_AXI_RRESP,
    output logic                                       S_AXI_RVALID,
    input  logic                                       S_AXI_RREADY,
    output logic [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0]   slv_reg,
    input  logic [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0]   slv_read,
    output logic [NREGS-1:0]                           wr_pulse,
    output logic [NREGS-1:0]                           rd_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    // write-side state
    wstate_t                       r_wstate,   w_wstate_nxt;
    logic                          r_awready,  w_awready_nxt;
    logic                          r_wready,   w_wready_nxt;
    logic                          r_aw_full,  w_aw_full_nxt;
    logic [IDX_W-1:0]              r_aw_idx,   w_aw_idx_nxt;
    logic                          r_w_full,   w_w_full_nxt;
    logic [DW-1:0]                 r_wdata,    w_wdata_nxt;
    logic [STRB_W-1:0]             r_wstrb,    w_wstrb_nxt;
    logic                          r_wcommit,  w_wcommit_nxt;
    logic                          r_bvalid,   w_bvalid_nxt;
    logic [1:0]                    r_bresp,    w_bresp_nxt;
    logic [NREGS-1:0][DW-1:0]      r_slv_reg,  w_slv_nxt;
    logic [NREGS-1:0]              r_wr_pulse, w_wr_pulse_nxt;

    // read-side state
    rstate_t                       r_rstate,   w_rstate_nxt;
    logic                          r_arready,  w_arready_nxt;
    logic                          r_rvalid,   w_rvalid_nxt;
    logic [DW-1:0]                 r_rdata,    w_rdata_nxt;
    logic [1:0]                    r_rresp,    w_rresp_nxt;
    logic [NREGS-1:0]              r_rd_pulse, w_rd_pulse_nxt;

    // decode helpers
    logic [IDX_W-1:0]              w_aw_addr_idx;
    logic [IDX_W-1:0]              w_ar_idx;
    logic [NREGS-1:0]              w_aw_sel;
    logic                          w_aw_legal;
    logic [NREGS-1:0]              w_ar_sel;
    logic                          w_ar_hit;
    logic [DW-1:0]                 w_ar_data;
    logic                          w_unused;

    assign w_aw_addr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign w_ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    // protection bits and sub-word address bits carry no meaning here
    assign w_unused      = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // One-hot select of the latched write index; an index beyond NREGS selects nothing
    always_comb begin
        w_aw_sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_aw_sel[i] = (r_aw_idx == IDX_W'(i));
        end
        w_aw_legal = |(w_aw_sel & ~RO_MASK);
    end

    // One-hot select and data mux for the incoming read address
    always_comb begin
        w_ar_sel  = '0;
        w_ar_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) begin
                w_ar_sel[i] = 1'b1;
                w_ar_data   = slv_read[i];
            end else begin
                w_ar_sel[i] = 1'b0;
            end
        end
        w_ar_hit = |w_ar_sel;
    end

    // Write FSM next-state: holder capture, single commit, B response
    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_aw_full_nxt  = r_aw_full;
        w_aw_idx_nxt   = r_aw_idx;
        w_w_full_nxt   = r_w_full;
        w_wdata_nxt    = r_wdata;
        w_wstrb_nxt    = r_wstrb;
        w_wcommit_nxt  = r_wcommit;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        w_wr_pulse_nxt = '0;
        // pulse registers fall back to zero unless written this cycle
        for (int i = 0; i < NREGS; i++) begin
            w_slv_nxt[i] = PULSE_MASK[i] ? {DW{1'b0}} : r_slv_reg[i];
        end

        case (r_wstate)
            W_IDLE: begin
                if (S_AXI_AWVALID && r_awready) begin
                    w_aw_full_nxt = 1'b1;
                    w_aw_idx_nxt  = w_aw_addr_idx;
                end else begin
                    w_aw_full_nxt = r_aw_full;
                end
                if (S_AXI_WVALID && r_wready) begin
                    w_w_full_nxt = 1'b1;
                    w_wdata_nxt  = S_AXI_WDATA;
                    w_wstrb_nxt  = S_AXI_WSTRB;
                end else begin
                    w_w_full_nxt = r_w_full;
                end
                if (r_wcommit) begin
                    // commit done last cycle: raise BVALID and free both holders
                    w_wstate_nxt  = W_RESP;
                    w_bvalid_nxt  = 1'b1;
                    w_aw_full_nxt = 1'b0;
                    w_w_full_nxt  = 1'b0;
                    w_wcommit_nxt = 1'b0;
                end else if (r_aw_full && r_w_full) begin
                    w_wcommit_nxt  = 1'b1;
                    w_bresp_nxt    = w_aw_legal ? RESP_OKAY : RESP_SLVERR;
                    w_wr_pulse_nxt = w_aw_sel & ~RO_MASK;
                    for (int i = 0; i < NREGS; i++) begin
                        for (int k = 0; k < STRB_W; k++) begin
                            w_slv_nxt[i][8*k +: 8] =
                                (w_aw_sel[i] && !RO_MASK[i] && r_wstrb[k]) ?
                                r_wdata[8*k +: 8] : w_slv_nxt[i][8*k +: 8];
                        end
                    end
                end else begin
                    w_wcommit_nxt = 1'b0;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_wstate_nxt = W_IDLE;
                    w_bvalid_nxt = 1'b0;
                end else begin
                    w_wstate_nxt = W_RESP;
                end
            end
            default: begin
                w_wstate_nxt  = W_IDLE;
                w_bvalid_nxt  = 1'b0;
                w_aw_full_nxt = 1'b0;
                w_w_full_nxt  = 1'b0;
                w_wcommit_nxt = 1'b0;
            end
        endcase

        w_awready_nxt = !w_aw_full_nxt && (w_wstate_nxt == W_IDLE);
        w_wready_nxt  = !w_w_full_nxt  && (w_wstate_nxt == W_IDLE);
    end

    // Write-side registers with synchronous active-low reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_full  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wcommit  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_slv_reg  <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_aw_full  <= w_aw_full_nxt;
            r_aw_idx   <= w_aw_idx_nxt;
            r_w_full   <= w_w_full_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_wcommit  <= w_wcommit_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
            r_slv_reg  <= w_slv_nxt;
            r_wr_pulse <= w_wr_pulse_nxt;
        end
    end

    // Read FSM next-state: one outstanding read, data captured at AR handshake
    always_comb begin
        w_rstate_nxt   = r_rstate;
        w_rvalid_nxt   = r_rvalid;
        w_rdata_nxt    = r_rdata;
        w_rresp_nxt    = r_rresp;
        w_rd_pulse_nxt = '0;
        case (r_rstate)
            R_IDLE: begin
                if (S_AXI_ARVALID && r_arready) begin
                    w_rstate_nxt   = R_DATA;
                    w_rvalid_nxt   = 1'b1;
                    w_rdata_nxt    = w_ar_data;
                    w_rresp_nxt    = w_ar_hit ? RESP_OKAY : RESP_SLVERR;
                    w_rd_pulse_nxt = w_ar_sel;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    w_rstate_nxt = R_IDLE;
                    w_rvalid_nxt = 1'b0;
                end else begin
                    w_rstate_nxt = R_DATA;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
                w_rvalid_nxt = 1'b0;
            end
        endcase
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
    end

    // Read-side registers with synchronous active-low reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_rstate   <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
            r_rd_pulse <= '0;
        end else begin
            r_rstate   <= w_rstate_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
            r_rd_pulse <= w_rd_pulse_nxt;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign slv_reg       = r_slv_reg;
    assign wr_pulse      = r_wr_pulse;
    assign rd_pulse      = r_rd_pulse;

endmodule
